// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-Lite encodings, slave state type and small decode helpers.
package ahb3lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HWORD = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_LAST = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_e;

    // Low-address-bit mask that must be zero for a transfer of 2**hsize bytes.
    function automatic logic [7:0] size_mask(input logic [2:0] hsize);
        return 8'((9'd1 << hsize) - 9'd1);
    endfunction

endpackage

// File: rtl/ahb3lite_sram_slave_if.sv
// AHB3-Lite bus signals between one master/interconnect and the SRAM slave.
interface ahb3lite_sram_slave_if #(
    parameter int unsigned HADDR_SIZE = 32,
    parameter int unsigned HDATA_SIZE = 32
);
    logic                  HSEL;
    logic [HADDR_SIZE-1:0] HADDR;
    logic [HDATA_SIZE-1:0] HWDATA;
    logic [HDATA_SIZE-1:0] HRDATA;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [2:0]            HBURST;
    logic [3:0]            HPROT;
    logic [1:0]            HTRANS;
    logic                  HREADY;
    logic                  HREADYOUT;
    logic                  HRESP;

    modport master (
        output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/ahb3lite_byte_en.sv
// Little-endian byte-lane enables for one transfer of 2**hsize bytes.
module ahb3lite_byte_en
    import ahb3lite_pkg::*;
#(
    parameter  int unsigned HDATA_SIZE = 32,
    localparam int unsigned BYTES      = HDATA_SIZE / 8,
    localparam int unsigned LANE_W     = $clog2(BYTES)
) (
    input  logic [2:0]        hsize,
    input  logic [LANE_W-1:0] addr_lo,
    output logic [BYTES-1:0]  byte_en
);

    int unsigned nbytes;
    int unsigned lo;

    // Enable every lane from addr_lo up to addr_lo + transfer bytes.
    always_comb begin
        byte_en = '0;
        lo      = 32'(addr_lo);
        case (hsize)
            HSIZE_BYTE:  nbytes = 32'd1;
            HSIZE_HWORD: nbytes = 32'd2;
            HSIZE_WORD:  nbytes = 32'd4;
            HSIZE_DWORD: nbytes = 32'd8;
            default:     nbytes = 32'd0;
        endcase
        for (int unsigned i = 0; i < BYTES; i++) begin
            byte_en[i] = (i >= lo) && (i < lo + nbytes);
        end
    end

endmodule

// File: rtl/ahb3lite_sram_slave.sv
// AHB3-Lite word-organised SRAM slave with programmable wait states and
// a two-cycle ERROR response for out-of-range, misaligned or oversize transfers.
module ahb3lite_sram_slave
    import ahb3lite_pkg::*;
#(
    parameter int unsigned          HADDR_SIZE  = 32,
    parameter int unsigned          HDATA_SIZE  = 32,
    parameter int unsigned          MEM_DEPTH   = 1024,
    parameter logic [HADDR_SIZE-1:0] BASE_ADDR  = '0,
    parameter int unsigned          WAIT_STATES = 0
) (
    input logic            HCLK,
    input logic            HRESETn,
    ahb3lite_sram_slave_if.slave bus
);

    localparam int unsigned BYTES     = HDATA_SIZE / 8;
    localparam int unsigned LANE_W    = $clog2(BYTES);
    localparam int unsigned IDX_W     = $clog2(MEM_DEPTH);
    localparam int unsigned MEM_BYTES = MEM_DEPTH * BYTES;
    localparam int unsigned CNT_W     = 4;

    logic [HDATA_SIZE-1:0] mem [MEM_DEPTH];

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [LANE_W-1:0]   lane_q, lane_d;
    logic [2:0]          size_q, size_d;
    logic                write_q, write_d;

    logic [HADDR_SIZE-1:0] offset_c;
    logic                  accept_c;
    logic                  illegal_c;
    logic [BYTES-1:0]      be_c;
    logic [HDATA_SIZE-1:0] wr_word_c;
    logic [HDATA_SIZE-1:0] rdata_c;
    logic                  unused_ok;

    // Address-phase decode: acceptance and legality of the presented transfer.
    always_comb begin
        offset_c  = bus.HADDR - BASE_ADDR;
        accept_c  = bus.HSEL && bus.HREADY &&
                    (bus.HTRANS == HTRANS_NONSEQ || bus.HTRANS == HTRANS_SEQ);
        illegal_c = (offset_c >= HADDR_SIZE'(MEM_BYTES)) ||
                    (32'(bus.HSIZE) > LANE_W) ||
                    ((bus.HADDR[7:0] & size_mask(bus.HSIZE)) != 8'd0);
    end

    assign unused_ok = ^{bus.HBURST, bus.HPROT, offset_c};

    // Next-state logic; a new accepted transfer overrides the current data phase.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        lane_d  = lane_q;
        size_d  = size_q;
        write_d = write_q;
        if (state_q == ST_ERR1) begin
            state_d = ST_ERR2;
        end else if (accept_c) begin
            if (illegal_c) begin
                state_d = ST_ERR1;
            end else begin
                idx_d   = offset_c[LANE_W +: IDX_W];
                lane_d  = offset_c[LANE_W-1:0];
                size_d  = bus.HSIZE;
                write_d = bus.HWRITE;
                if (WAIT_STATES > 0) begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_W'(WAIT_STATES - 1);
                end else begin
                    state_d = ST_LAST;
                end
            end
        end else begin
            case (state_q)
                ST_WAIT: begin
                    if (cnt_q == '0) state_d = ST_LAST;
                    else             cnt_d   = cnt_q - CNT_W'(1);
                end
                ST_LAST, ST_ERR2: state_d = ST_IDLE;
                default: ;
            endcase
        end
    end

    // State and registered address-phase fields.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            lane_q  <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            lane_q  <= lane_d;
            size_q  <= size_d;
            write_q <= write_d;
        end
    end

    ahb3lite_byte_en #(.HDATA_SIZE(HDATA_SIZE)) u_byte_en (
        .hsize   (size_q),
        .addr_lo (lane_q),
        .byte_en (be_c)
    );

    // Merge enabled HWDATA lanes into the current word, keeping other lanes.
    always_comb begin
        wr_word_c = mem[idx_q];
        for (int unsigned i = 0; i < BYTES; i++) begin
            if (be_c[i]) wr_word_c[8*i +: 8] = bus.HWDATA[8*i +: 8];
        end
    end

    // Write commits on the edge that ends LAST; storage has no reset.
    always_ff @(posedge HCLK) begin
        if (state_q == ST_LAST && write_q) mem[idx_q] <= wr_word_c;
    end

    // Read data is driven only during a read's data phase, full word unmasked.
    always_comb begin
        rdata_c = '0;
        if ((state_q == ST_WAIT || state_q == ST_LAST) && !write_q) rdata_c = mem[idx_q];
    end

    assign bus.HRDATA    = rdata_c;
    assign bus.HREADYOUT = !(state_q == ST_WAIT || state_q == ST_ERR1);
    assign bus.HRESP     = (state_q == ST_ERR1 || state_q == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;

endmodule

// File: tb/tb_ahb3lite_sram_slave.sv
// Directed bench: three slaves (0, 2 and 3 wait states) on shared stimulus.
module tb_ahb3lite_sram_slave;
    import ahb3lite_pkg::*;

    localparam int D0 = 0;   // WAIT_STATES=0, BASE 0
    localparam int D2 = 1;   // WAIT_STATES=2, BASE 0x4000
    localparam int D3 = 2;   // WAIT_STATES=3, BASE 0

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic [2:0]  hsel;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [1:0]  htrans;

    int tests = 0;
    int fails = 0;

    always #5 HCLK = ~HCLK;

    ahb3lite_sram_slave_if #(.HADDR_SIZE(32), .HDATA_SIZE(32)) bus0 ();
    ahb3lite_sram_slave_if #(.HADDR_SIZE(32), .HDATA_SIZE(32)) bus2 ();
    ahb3lite_sram_slave_if #(.HADDR_SIZE(32), .HDATA_SIZE(32)) bus3 ();

    assign bus0.HSEL = hsel[D0];  assign bus2.HSEL = hsel[D2];  assign bus3.HSEL = hsel[D3];
    assign bus0.HADDR = haddr;    assign bus2.HADDR = haddr;    assign bus3.HADDR = haddr;
    assign bus0.HWDATA = hwdata;  assign bus2.HWDATA = hwdata;  assign bus3.HWDATA = hwdata;
    assign bus0.HWRITE = hwrite;  assign bus2.HWRITE = hwrite;  assign bus3.HWRITE = hwrite;
    assign bus0.HSIZE = hsize;    assign bus2.HSIZE = hsize;    assign bus3.HSIZE = hsize;
    assign bus0.HTRANS = htrans;  assign bus2.HTRANS = htrans;  assign bus3.HTRANS = htrans;
    assign bus0.HBURST = 3'd0;    assign bus2.HBURST = 3'd0;    assign bus3.HBURST = 3'd0;
    assign bus0.HPROT = 4'b0011;  assign bus2.HPROT = 4'b0011;  assign bus3.HPROT = 4'b0011;
    assign bus0.HREADY = bus0.HREADYOUT;
    assign bus2.HREADY = bus2.HREADYOUT;
    assign bus3.HREADY = bus3.HREADYOUT;

    ahb3lite_sram_slave #(.HADDR_SIZE(32), .HDATA_SIZE(32), .MEM_DEPTH(1024),
                          .BASE_ADDR(32'h0), .WAIT_STATES(0)) dut0 (
        .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus0));
    ahb3lite_sram_slave #(.HADDR_SIZE(32), .HDATA_SIZE(32), .MEM_DEPTH(1024),
                          .BASE_ADDR(32'h4000), .WAIT_STATES(2)) dut2 (
        .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus2));
    ahb3lite_sram_slave #(.HADDR_SIZE(32), .HDATA_SIZE(32), .MEM_DEPTH(1024),
                          .BASE_ADDR(32'h0), .WAIT_STATES(3)) dut3 (
        .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus3));

    logic [2:0]  rdy_w;
    logic [2:0]  resp_w;
    logic [31:0] rdata_w [3];
    assign rdy_w      = {bus3.HREADYOUT, bus2.HREADYOUT, bus0.HREADYOUT};
    assign resp_w     = {bus3.HRESP, bus2.HRESP, bus0.HRESP};
    assign rdata_w[0] = bus0.HRDATA;
    assign rdata_w[1] = bus2.HRDATA;
    assign rdata_w[2] = bus3.HRDATA;

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    // One non-pipelined transfer; reports data-phase length and response.
    task automatic xfer(input int d, input logic wr, input logic [31:0] addr,
                        input logic [2:0] size, input logic [31:0] wdata,
                        output logic [31:0] rdata, output int cycles,
                        output logic first_rdy, output logic first_resp,
                        output logic last_resp);
        hsel   = 3'b001 << d;
        haddr  = addr;
        hwrite = wr;
        hsize  = size;
        htrans = HTRANS_NONSEQ;
        step();
        htrans     = HTRANS_IDLE;
        hwdata     = wdata;
        cycles     = 1;
        first_rdy  = rdy_w[d];
        first_resp = resp_w[d];
        while (rdy_w[d] !== 1'b1 && cycles < 40) begin
            step();
            cycles++;
        end
        if (rdy_w[d] !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL xfer_timeout: dut %0d addr %h never ready after %0d cycles", d, addr, cycles);
        end
        rdata     = rdata_w[d];
        last_resp = resp_w[d];
        step();
    endtask

    task automatic test_reset();
        for (int d = 0; d < 3; d++) begin
            tests++; if (rdy_w[d] !== 1'b1) begin fails++; $display("FAIL reset_hreadyout[%0d]: got %b expected 1", d, rdy_w[d]); end
            tests++; if (resp_w[d] !== 1'b0) begin fails++; $display("FAIL reset_hresp[%0d]: got %b expected 0", d, resp_w[d]); end
            tests++; if (rdata_w[d] !== 32'h0) begin fails++; $display("FAIL reset_hrdata[%0d]: got %h expected 0", d, rdata_w[d]); end
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] rd; int cyc; logic fr, fp, lp;
        xfer(D3, 1'b1, 32'h10, HSIZE_WORD, 32'h1122_3344, rd, cyc, fr, fp, lp);
        hsel = 3'b100; haddr = 32'h10; hwrite = 1'b1; hsize = HSIZE_WORD; htrans = HTRANS_NONSEQ;
        step();
        htrans = HTRANS_IDLE; hwdata = 32'h5566_7788;
        tests++; if (rdy_w[D3] !== 1'b0) begin fails++; $display("FAIL rstwait_in_wait: got %b expected 0", rdy_w[D3]); end
        #2 HRESETn = 1'b0;
        #1;
        tests++; if (rdy_w[D3] !== 1'b1) begin fails++; $display("FAIL rstwait_hreadyout: got %b expected 1", rdy_w[D3]); end
        tests++; if (resp_w[D3] !== 1'b0) begin fails++; $display("FAIL rstwait_hresp: got %b expected 0", resp_w[D3]); end
        step();
        step();
        HRESETn = 1'b1;
        step();
        xfer(D3, 1'b0, 32'h10, HSIZE_WORD, 32'h0, rd, cyc, fr, fp, lp);
        tests++; if (rd !== 32'h1122_3344) begin fails++; $display("FAIL rstwait_old_data: got %h expected 11223344", rd); end
        tests++; if (cyc !== 4) begin fails++; $display("FAIL rstwait_read_cycles: got %0d expected 4", cyc); end
    endtask

    task automatic test_back_to_back();
        hsel = 3'b001; haddr = 32'h04; hwrite = 1'b1; hsize = HSIZE_WORD; htrans = HTRANS_NONSEQ;
        step();
        tests++; if (rdy_w[D0] !== 1'b1) begin fails++; $display("FAIL b2b_write_ready: got %b expected 1", rdy_w[D0]); end
        hwdata = 32'hDEAD_BEEF; hwrite = 1'b0; haddr = 32'h04; htrans = HTRANS_NONSEQ;
        step();
        htrans = HTRANS_IDLE;
        tests++; if (rdy_w[D0] !== 1'b1) begin fails++; $display("FAIL b2b_read_ready: got %b expected 1", rdy_w[D0]); end
        tests++; if (rdata_w[D0] !== 32'hDEAD_BEEF) begin fails++; $display("FAIL b2b_read_data: got %h expected deadbeef", rdata_w[D0]); end
        tests++; if (resp_w[D0] !== 1'b0) begin fails++; $display("FAIL b2b_read_resp: got %b expected 0", resp_w[D0]); end
        step();
        tests++; if (rdata_w[D0] !== 32'h0) begin fails++; $display("FAIL b2b_idle_rdata: got %h expected 0", rdata_w[D0]); end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd; int cyc; logic fr, fp, lp;
        xfer(D0, 1'b1, 32'h05, HSIZE_BYTE,  32'hFFFF_AAFF, rd, cyc, fr, fp, lp);
        xfer(D0, 1'b1, 32'h06, HSIZE_HWORD, 32'h1234_9999, rd, cyc, fr, fp, lp);
        xfer(D0, 1'b0, 32'h04, HSIZE_WORD,  32'h0, rd, cyc, fr, fp, lp);
        tests++; if (rd !== 32'h1234_AAEF) begin fails++; $display("FAIL lanes_word: got %h expected 1234aaef", rd); end
        xfer(D0, 1'b0, 32'h07, HSIZE_BYTE,  32'h0, rd, cyc, fr, fp, lp);
        tests++; if (rd !== 32'h1234_AAEF) begin fails++; $display("FAIL lanes_byte_read: got %h expected 1234aaef", rd); end
    endtask

    task automatic test_wait_states();
        logic [31:0] rd; int cyc; logic fr, fp, lp;
        xfer(D2, 1'b1, 32'h4008, HSIZE_WORD, 32'hCAFE_F00D, rd, cyc, fr, fp, lp);
        tests++; if (cyc !== 3) begin fails++; $display("FAIL ws_write_cycles: got %0d expected 3", cyc); end
        xfer(D2, 1'b0, 32'h4008, HSIZE_WORD, 32'h0, rd, cyc, fr, fp, lp);
        tests++; if (cyc !== 3) begin fails++; $display("FAIL ws_read_cycles: got %0d expected 3", cyc); end
        tests++; if (fr !== 1'b0) begin fails++; $display("FAIL ws_first_ready: got %b expected 0", fr); end
        tests++; if (rd !== 32'hCAFE_F00D) begin fails++; $display("FAIL ws_read_data: got %h expected cafef00d", rd); end
        tests++; if (lp !== 1'b0) begin fails++; $display("FAIL ws_resp: got %b expected 0", lp); end
        xfer(D2, 1'b0, 32'h3FFC, HSIZE_WORD, 32'h0, rd, cyc, fr, fp, lp);
        tests++; if (cyc !== 2 || fr !== 1'b0 || fp !== 1'b1 || lp !== 1'b1) begin fails++;
            $display("FAIL below_base_err: got cyc=%0d rdy1=%b resp1=%b resp2=%b expected 2 0 1 1", cyc, fr, fp, lp); end
    endtask

    task automatic test_error();
        hsel = 3'b001; haddr = 32'h1000; hwrite = 1'b0; hsize = HSIZE_WORD; htrans = HTRANS_NONSEQ;
        step();
        haddr = 32'h04;
        tests++; if ({rdy_w[D0], resp_w[D0]} !== 2'b01) begin fails++; $display("FAIL err1_rdy_resp: got %b expected 01", {rdy_w[D0], resp_w[D0]}); end
        tests++; if (rdata_w[D0] !== 32'h0) begin fails++; $display("FAIL err1_rdata: got %h expected 0", rdata_w[D0]); end
        step();
        tests++; if ({rdy_w[D0], resp_w[D0]} !== 2'b11) begin fails++; $display("FAIL err2_rdy_resp: got %b expected 11", {rdy_w[D0], resp_w[D0]}); end
        tests++; if (rdata_w[D0] !== 32'h0) begin fails++; $display("FAIL err2_rdata: got %h expected 0", rdata_w[D0]); end
        step();
        htrans = HTRANS_IDLE;
        tests++; if ({rdy_w[D0], resp_w[D0]} !== 2'b10) begin fails++; $display("FAIL after_err_okay: got %b expected 10", {rdy_w[D0], resp_w[D0]}); end
        tests++; if (rdata_w[D0] !== 32'h1234_AAEF) begin fails++; $display("FAIL after_err_data: got %h expected 1234aaef", rdata_w[D0]); end
        step();
    endtask

    task automatic test_misaligned();
        logic [31:0] rd; int cyc; logic fr, fp, lp;
        xfer(D0, 1'b1, 32'h00, HSIZE_WORD, 32'h0102_0304, rd, cyc, fr, fp, lp);
        hsel = 3'b001; haddr = 32'h02; hwrite = 1'b1; hsize = HSIZE_WORD; htrans = HTRANS_NONSEQ;
        step();
        htrans = HTRANS_BUSY; hwdata = 32'hFFFF_FFFF;
        tests++; if ({rdy_w[D0], resp_w[D0]} !== 2'b01) begin fails++; $display("FAIL mis_err1: got %b expected 01", {rdy_w[D0], resp_w[D0]}); end
        step();
        tests++; if ({rdy_w[D0], resp_w[D0]} !== 2'b11) begin fails++; $display("FAIL mis_err2: got %b expected 11", {rdy_w[D0], resp_w[D0]}); end
        step();
        htrans = HTRANS_IDLE;
        tests++; if ({rdy_w[D0], resp_w[D0]} !== 2'b10) begin fails++; $display("FAIL busy_okay: got %b expected 10", {rdy_w[D0], resp_w[D0]}); end
        xfer(D0, 1'b0, 32'h00, HSIZE_WORD, 32'h0, rd, cyc, fr, fp, lp);
        tests++; if (rd !== 32'h0102_0304) begin fails++; $display("FAIL mis_word0: got %h expected 01020304", rd); end
        xfer(D0, 1'b0, 32'h04, HSIZE_WORD, 32'h0, rd, cyc, fr, fp, lp);
        tests++; if (rd !== 32'h1234_AAEF) begin fails++; $display("FAIL mis_word1: got %h expected 1234aaef", rd); end
    endtask

    task automatic test_boundaries();
        logic [31:0] rd; int cyc; logic fr, fp, lp;
        xfer(D0, 1'b0, 32'h08, HSIZE_DWORD, 32'h0, rd, cyc, fr, fp, lp);
        tests++; if (cyc !== 2 || fr !== 1'b0 || fp !== 1'b1 || lp !== 1'b1) begin fails++;
            $display("FAIL oversize_err: got cyc=%0d rdy1=%b resp1=%b resp2=%b expected 2 0 1 1", cyc, fr, fp, lp); end
        xfer(D0, 1'b1, 32'hFFC, HSIZE_WORD, 32'hA5A5_5A5A, rd, cyc, fr, fp, lp);
        xfer(D0, 1'b0, 32'hFFC, HSIZE_WORD, 32'h0, rd, cyc, fr, fp, lp);
        tests++; if (rd !== 32'hA5A5_5A5A || lp !== 1'b0 || cyc !== 1) begin fails++;
            $display("FAIL last_word: got data=%h resp=%b cyc=%0d expected a5a55a5a 0 1", rd, lp, cyc); end
    endtask

    initial begin
        HRESETn = 1'b0;
        hsel = 3'b000; haddr = 32'h0; hwdata = 32'h0; hwrite = 1'b0;
        hsize = HSIZE_WORD; htrans = HTRANS_IDLE;
        repeat (3) @(posedge HCLK);
        #1 HRESETn = 1'b1;
        test_reset();
        test_reset_mid_wait();
        test_back_to_back();
        test_byte_lanes();
        test_wait_states();
        test_error();
        test_misaligned();
        test_boundaries();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, %0d tests run", tests);
        $fatal(1, "timeout");
    end

endmodule
